// File: rtl/mantissa_mul_pkg.sv
// Shared definitions for the multi-precision mantissa multiplier front-end:
// array mode encodings, datapath widths and per-request result metadata.
package mantissa_mul_pkg;

  localparam logic [1:0] MODE_4X7  = 2'b00;
  localparam logic [1:0] MODE_2X14 = 2'b01;
  localparam logic [1:0] MODE_1X28 = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  localparam int MANT_W = 28;
  localparam int PROD_W = 56;

  // Widest tag the metadata can carry; requester tags are zero-extended into it.
  localparam int META_TAG_W = 16;

  typedef struct packed {
    logic [META_TAG_W-1:0] tag;
    logic                  src;
    logic                  err;
  } res_meta_t;

endpackage

// File: rtl/mul_result_fifo.sv
// Synchronous result FIFO with register-backed head output; push and pop may
// coincide at any occupancy, including full and empty.
module mul_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [0:DEPTH-1];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic             valid_r;
  logic             do_push_s, do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return PTR_ZERO;
    end else begin
      return p + PTR_ONE;
    end
  endfunction

  // Qualify push/pop against occupancy and compute the next fill level.
  always_comb begin
    do_pop_s  = pop && (count_r != CNT_ZERO);
    do_push_s = push && ((count_r != CNT_FULL) || do_pop_s);
    case ({do_push_s, do_pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, fill level and the registered valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      valid_r  <= 1'b0;
    end else begin
      if (do_push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (do_pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != CNT_ZERO);
    end
  end

  // Storage; cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign valid = valid_r;

endmodule

// File: rtl/mantissa_mul_scheduler.sv
// Front-end scheduler for the shared 28x28 mantissa multiplier array: round-robin
// issue from two FMA ports, in-flight tracking, credit-protected result return.
module mantissa_mul_scheduler
  import mantissa_mul_pkg::*;
#(
  parameter int LAT        = 2,
  parameter int TAG_W      = 4,
  parameter int OBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_mode,
  input  logic [MANT_W-1:0] req0_a,
  input  logic [MANT_W-1:0] req0_b,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_mode,
  input  logic [MANT_W-1:0] req1_a,
  input  logic [MANT_W-1:0] req1_b,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic [1:0]        mul_op,
  output logic [MANT_W-1:0] mul_a,
  output logic [MANT_W-1:0] mul_b,
  input  logic [PROD_W-1:0] mul_prod,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [PROD_W-1:0] rsp_prod,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_src,
  output logic              rsp_err,
  output logic              busy
);
  localparam int CRED_W = $clog2(OBUF_DEPTH + 1);
  localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(OBUF_DEPTH);
  localparam logic [CRED_W-1:0] CRED_ZERO = {CRED_W{1'b0}};
  localparam logic [CRED_W-1:0] CRED_ONE  = CRED_W'(1);
  localparam int FIFO_W = PROD_W + TAG_W + 2;
  localparam logic [MANT_W-1:0] MANT_ZERO = {MANT_W{1'b0}};

  logic [CRED_W-1:0] credits_r, credits_nxt_s;
  logic              rr_r, rr_nxt_s;
  logic              grant_en_s, grant0_s, grant1_s, accept_s, pop_s;
  logic [1:0]        sel_mode_s;
  logic [MANT_W-1:0] sel_a_s, sel_b_s, issue_a_s, issue_b_s;
  res_meta_t         sel_meta_s;
  logic [1:0]        mul_op_r;
  logic [MANT_W-1:0] mul_a_r, mul_b_r;
  logic              busy_r;
  logic [LAT:0]      trk_vld_r;
  res_meta_t         trk_meta_r [0:LAT];
  logic [FIFO_W-1:0] fifo_din_s, fifo_dout_s;
  logic              fifo_valid_s;

  // Round-robin grant gated by credit; each ready looks only at the other port's valid.
  always_comb begin
    grant_en_s = rst_n && (credits_r != CRED_ZERO);
    req0_ready = grant_en_s && (!req1_valid || !rr_r);
    req1_ready = grant_en_s && (!req0_valid || rr_r);
    grant0_s   = req0_valid && req0_ready;
    grant1_s   = req1_valid && req1_ready;
    accept_s   = grant0_s || grant1_s;
    if (grant0_s) begin
      rr_nxt_s = 1'b1;
    end else if (grant1_s) begin
      rr_nxt_s = 1'b0;
    end else begin
      rr_nxt_s = rr_r;
    end
  end

  // Mux the granted request; mode 11 and idle cycles drive the array gated off with zero operands.
  always_comb begin
    sel_mode_s = MODE_OFF;
    sel_a_s    = MANT_ZERO;
    sel_b_s    = MANT_ZERO;
    sel_meta_s = {$bits(res_meta_t){1'b0}};
    if (grant0_s) begin
      sel_mode_s     = req0_mode;
      sel_a_s        = req0_a;
      sel_b_s        = req0_b;
      sel_meta_s.tag = META_TAG_W'(req0_tag);
      sel_meta_s.src = 1'b0;
      sel_meta_s.err = (req0_mode == MODE_OFF);
    end else if (grant1_s) begin
      sel_mode_s     = req1_mode;
      sel_a_s        = req1_a;
      sel_b_s        = req1_b;
      sel_meta_s.tag = META_TAG_W'(req1_tag);
      sel_meta_s.src = 1'b1;
      sel_meta_s.err = (req1_mode == MODE_OFF);
    end else begin
      sel_mode_s = MODE_OFF;
      sel_meta_s = {$bits(res_meta_t){1'b0}};
    end
    if (sel_mode_s == MODE_OFF) begin
      issue_a_s = MANT_ZERO;
      issue_b_s = MANT_ZERO;
    end else begin
      issue_a_s = sel_a_s;
      issue_b_s = sel_b_s;
    end
  end

  // Credit update: take on accept, return on pop, unchanged when both happen.
  always_comb begin
    pop_s = fifo_valid_s && rsp_ready;
    case ({accept_s, pop_s})
      2'b10:   credits_nxt_s = credits_r - CRED_ONE;
      2'b01:   credits_nxt_s = credits_r + CRED_ONE;
      default: credits_nxt_s = credits_r;
    endcase
  end

  // Credit pool, round-robin pointer and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_r <= CRED_FULL;
      rr_r      <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      credits_r <= credits_nxt_s;
      rr_r      <= rr_nxt_s;
      busy_r    <= (credits_nxt_s != CRED_FULL);
    end
  end

  // Operand/op register feeding the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_op_r <= MODE_OFF;
      mul_a_r  <= MANT_ZERO;
      mul_b_r  <= MANT_ZERO;
    end else begin
      mul_op_r <= sel_mode_s;
      mul_a_r  <= issue_a_s;
      mul_b_r  <= issue_b_s;
    end
  end

  // Metadata shift register, stage 0 aligned with the operand register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_vld_r <= {(LAT + 1){1'b0}};
      for (int k = 0; k <= LAT; k++) trk_meta_r[k] <= {$bits(res_meta_t){1'b0}};
    end else begin
      trk_vld_r     <= {trk_vld_r[LAT-1:0], accept_s};
      trk_meta_r[0] <= sel_meta_s;
      for (int k = 1; k <= LAT; k++) trk_meta_r[k] <= trk_meta_r[k-1];
    end
  end

  assign fifo_din_s = {mul_prod, trk_meta_r[LAT].tag[TAG_W-1:0],
                       trk_meta_r[LAT].src, trk_meta_r[LAT].err};

  mul_result_fifo #(
    .DEPTH (OBUF_DEPTH),
    .WIDTH (FIFO_W)
  ) u_obuf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (trk_vld_r[LAT]),
    .din   (fifo_din_s),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .valid (fifo_valid_s)
  );

  assign mul_op    = mul_op_r;
  assign mul_a     = mul_a_r;
  assign mul_b     = mul_b_r;
  assign busy      = busy_r;
  assign rsp_valid = fifo_valid_s;
  assign rsp_prod  = fifo_dout_s[FIFO_W-1 -: PROD_W];
  assign rsp_tag   = fifo_dout_s[TAG_W+1:2];
  assign rsp_src   = fifo_dout_s[1];
  assign rsp_err   = fifo_dout_s[0];

endmodule

// File: tb/tb_mantissa_mul_scheduler.sv
// Directed bench for mantissa_mul_scheduler with a lane-accurate array model on mul_prod.
module tb_mantissa_mul_scheduler;
  localparam int LAT   = 2;
  localparam int TAG_W = 4;
  localparam int DEPTH = 4;

  logic clk, rst_n;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0] req0_mode, req1_mode, mul_op;
  logic [27:0] req0_a, req0_b, req1_a, req1_b, mul_a, mul_b;
  logic [TAG_W-1:0] req0_tag, req1_tag, rsp_tag;
  logic [55:0] mul_prod, rsp_prod;
  logic rsp_valid, rsp_ready, rsp_src, rsp_err, busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [55:0] prod_pipe [0:LAT-1];

  mantissa_mul_scheduler #(.LAT(LAT), .TAG_W(TAG_W), .OBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
    .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
    .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .mul_op(mul_op), .mul_a(mul_a), .mul_b(mul_b), .mul_prod(mul_prod),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_prod(rsp_prod),
    .rsp_tag(rsp_tag), .rsp_src(rsp_src), .rsp_err(rsp_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [55:0] arr_mul(input logic [1:0] op, input logic [27:0] a,
                                          input logic [27:0] b);
    logic [55:0] r;
    logic [13:0] x7, y7;
    logic [27:0] x14, y14;
    logic [55:0] x28, y28;
    r = 56'h0;
    case (op)
      2'b00: for (int i = 0; i < 4; i++) begin
        x7 = {7'h0, a[7*i +: 7]};
        y7 = {7'h0, b[7*i +: 7]};
        r[14*i +: 14] = x7 * y7;
      end
      2'b01: for (int i = 0; i < 2; i++) begin
        x14 = {14'h0, a[14*i +: 14]};
        y14 = {14'h0, b[14*i +: 14]};
        r[28*i +: 28] = x14 * y14;
      end
      2'b10: begin
        x28 = {28'h0, a};
        y28 = {28'h0, b};
        r = x28 * y28;
      end
      default: r = 56'h0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    prod_pipe[0] <= arr_mul(mul_op, mul_a, mul_b);
    for (int k = 1; k < LAT; k++) prod_pipe[k] <= prod_pipe[k-1];
  end
  assign mul_prod = prod_pipe[LAT-1];

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 30) begin
      tick();
      cyc++;
    end
  endtask

  task automatic pop_one();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  int n, n_acc, exp_k, stale;
  logic acc;

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_mode = 2'b00; req0_a = 28'h0; req0_b = 28'h0; req0_tag = 4'h0;
    req1_valid = 1'b0; req1_mode = 2'b00; req1_a = 28'h0; req1_b = 28'h0; req1_tag = 4'h0;
    #12;
    check_eq("rst_mul_op", mul_op, 2'b11);
    check_eq("rst_mul_a", mul_a, 28'h0);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_req0_ready", req0_ready, 1'b0);
    req0_valid = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    tick();

    // single 1x28 request on port 0
    req0_valid = 1'b1; req0_mode = 2'b10; req0_a = 28'h0000003; req0_b = 28'h0000005; req0_tag = 4'h7;
    #1 check_eq("t1_ready", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    check_eq("t1_mul_op", mul_op, 2'b10);
    check_eq("t1_mul_a", mul_a, 28'h3);
    check_eq("t1_mul_b", mul_b, 28'h5);
    wait_rsp(n);
    check_eq("t1_latency", n + 1, 2 + LAT);
    check_eq("t1_prod", rsp_prod, 56'h0F);
    check_eq("t1_tag", rsp_tag, 4'h7);
    check_eq("t1_src", rsp_src, 1'b0);
    check_eq("t1_err", rsp_err, 1'b0);
    tick();
    check_eq("t1_hold_valid", rsp_valid, 1'b1);
    check_eq("t1_hold_prod", rsp_prod, 56'h0F);
    pop_one();
    check_eq("t1_busy_after_pop", busy, 1'b0);
    check_eq("t1_empty_after_pop", rsp_valid, 1'b0);

    // illegal mode 11 on port 1
    req1_valid = 1'b1; req1_mode = 2'b11; req1_a = 28'hFFFFFFF; req1_b = 28'hFFFFFFF; req1_tag = 4'h3;
    #1 check_eq("m11_ready", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    check_eq("m11_mul_op", mul_op, 2'b11);
    check_eq("m11_mul_a", mul_a, 28'h0);
    check_eq("m11_mul_b", mul_b, 28'h0);
    wait_rsp(n);
    check_eq("m11_latency", n + 1, 2 + LAT);
    check_eq("m11_err", rsp_err, 1'b1);
    check_eq("m11_prod", rsp_prod, 56'h0);
    check_eq("m11_tag", rsp_tag, 4'h3);
    check_eq("m11_src", rsp_src, 1'b1);
    check_eq("m11_busy", busy, 1'b1);
    pop_one();
    check_eq("m11_credit_back", busy, 1'b0);

    // both ports valid: alternating grants
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_mode = 2'b10; req0_a = 28'h2; req0_b = 28'h3; req0_tag = 4'h1;
    req1_valid = 1'b1; req1_mode = 2'b01; req1_a = {14'd2, 14'd3}; req1_b = {14'd5, 14'd7}; req1_tag = 4'h2;
    for (int i = 0; i < 4; i++) begin
      #1 check_eq("rr_grant", {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_rsp(n);
      check_eq("rr_rsp_valid", rsp_valid, 1'b1);
      check_eq("rr_src", rsp_src, (i % 2 == 0) ? 1'b0 : 1'b1);
      check_eq("rr_tag", rsp_tag, (i % 2 == 0) ? 4'h1 : 4'h2);
      check_eq("rr_prod", rsp_prod, (i % 2 == 0) ? 56'h6 : 56'h000000A0000015);
      tick();
    end

    // mode change 4x7 -> 2x14 on consecutive cycles
    req0_valid = 1'b1; req0_mode = 2'b00; req0_tag = 4'h4;
    req0_a = {7'd1, 7'd2, 7'd3, 7'd4}; req0_b = {7'd5, 7'd6, 7'd7, 7'd8};
    tick();
    check_eq("mc_op0", mul_op, 2'b00);
    req0_mode = 2'b01; req0_tag = 4'h5; req0_a = {14'd6, 14'd11}; req0_b = {14'd9, 14'd13};
    tick();
    req0_valid = 1'b0;
    check_eq("mc_op1", mul_op, 2'b01);
    check_eq("mc_a1", mul_a, {14'd6, 14'd11});
    wait_rsp(n);
    check_eq("mc_prod0", rsp_prod, 56'h001400C0054020);
    check_eq("mc_tag0", rsp_tag, 4'h4);
    tick();
    check_eq("mc_valid1", rsp_valid, 1'b1);
    check_eq("mc_prod1", rsp_prod, 56'h0000036000008F);
    check_eq("mc_tag1", rsp_tag, 4'h5);
    tick(); tick();
    check_eq("mc_idle_busy", busy, 1'b0);

    // backpressure: credit pool limits acceptance to the buffer depth
    rsp_ready = 1'b0; n_acc = 0;
    req0_valid = 1'b1; req0_mode = 2'b10; req0_a = 28'd1; req0_b = 28'd2; req0_tag = 4'h0;
    for (int c = 0; c < 10; c++) begin
      #1 acc = req0_ready;
      tick();
      if (acc) begin
        n_acc++;
        req0_tag = 4'(n_acc);
        req0_a = 28'(n_acc + 1);
      end
    end
    check_eq("bp_accepted", n_acc, DEPTH);
    #1 check_eq("bp_ready_low", req0_ready, 1'b0);
    check_eq("bp_busy", busy, 1'b1);
    rsp_ready = 1'b1; exp_k = 0;
    for (int c = 0; c < 40 && exp_k < 6; c++) begin
      #1 acc = req0_valid && req0_ready;
      if (rsp_valid) begin
        check_eq("bp_tag", rsp_tag, 4'(exp_k));
        check_eq("bp_prod", rsp_prod, 56'(2 * (exp_k + 1)));
        exp_k++;
      end
      tick();
      if (acc) begin
        n_acc++;
        if (n_acc == 6) begin
          req0_valid = 1'b0;
        end else begin
          req0_tag = 4'(n_acc);
          req0_a = 28'(n_acc + 1);
        end
      end
    end
    check_eq("bp_all_popped", exp_k, 6);
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid) stale++;
      tick();
    end
    check_eq("bp_no_dup", stale, 0);
    check_eq("bp_busy_end", busy, 1'b0);

    // reset with 2 buffered and 2 in flight
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_mode = 2'b10; req0_a = 28'd7; req0_b = 28'd9; req0_tag = 4'h9;
    for (int c = 0; c < 4; c++) begin
      #1 check_eq("rmo_ready", req0_ready, 1'b1);
      tick();
    end
    tick();
    check_eq("rmo_buffered", rsp_valid, 1'b1);
    check_eq("rmo_prod_pre", rsp_prod, 56'd63);
    rst_n = 1'b0;
    #1;
    check_eq("rmo_rsp_valid", rsp_valid, 1'b0);
    check_eq("rmo_rsp_prod", rsp_prod, 56'h0);
    check_eq("rmo_rsp_tag", rsp_tag, 4'h0);
    check_eq("rmo_busy", busy, 1'b0);
    check_eq("rmo_mul_op", mul_op, 2'b11);
    check_eq("rmo_ready_in_rst", req0_ready, 1'b0);
    req0_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid) stale++;
      tick();
    end
    check_eq("rmo_no_stale", stale, 0);
    check_eq("rmo_busy_after", busy, 1'b0);
    check_eq("rmo_ready_after", req0_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
